instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Pipeline fetch stage directly upstream of the MMU instruction port. Owns the PC and drives
//  instructionMemoryAddress. Accepts instruction words only when instructionMemorySuccess is high.
//  Presents each instruction to decode through a one-entry valid/ready buffer.
//  Handles branch redirects and counts fetch stall cycles.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset
//  STALL_CNT_W  16             width of saturating stall counter
// PORTS
//  clk                         in   1   system clock, all state on rising edge
//  reset                       in   1   synchronous, active-low reset
//  instructionMemoryAddress    out  32  fetch address to MMU; always equals internal pc register
//  instructionMemorySuccess    in   1   MMU: data for current address valid this cycle
//  instructionMemoryDataIn     in   32  MMU instruction word
//  branchTaken                 in   1   redirect request from execute
//  branchTarget                in   32  redirect PC; bits [1:0] ignored
//  decodeReady                 in   1   decode consumes buffer this cycle when fetchValid=1
//  fetchValid                  out  1   buffer holds a valid instruction
//  fetchInstruction            out  32  buffered instruction word
//  fetchPc                     out  32  PC of fetchInstruction
//  fetchStallCycles            out  STALL_CNT_W  cycles spent in FETCH with success low (saturating)
// BEHAVIOUR
//  Reset (reset==0 at edge):
//   - pc=RESET_PC, so the address reads RESET_PC.
//   - fetchValid=0, fetchInstruction=0, fetchPc=0, fetchStallCycles=0, state=FETCH.
//  Reset overrides every other input, including mid-stall and mid-redirect.
//  States:
//   FETCH: address=pc.
//    - accept = success & (!fetchValid | decodeReady).
//    - On accept: buffer<=(dataIn,pc), fetchValid<=1, pc<=pc+4 (mod 2^32, wraps), stay FETCH.
//    - success & fetchValid & !decodeReady -> FULL. pc is held; the word is not captured.
//    - !success -> stay FETCH, pc held, stall counter +1 (saturates at all-ones).
//      If fetchValid & decodeReady in this case, fetchValid<=0.
//   FULL: address=pc held, buffer contents held stable.
//    - decodeReady -> fetchValid<=0, go to FETCH. No capture in this cycle.
//    - Stall counter does not count in FULL.
//  Redirect: branchTaken=1 in any state takes priority over everything except reset.
//   - pc<={branchTarget[31:2],2'b00}, fetchValid<=0, state<=FETCH.
//   - Success and data in the redirect cycle are discarded, as is any buffered instruction.
//   - The stall counter is not incremented in the redirect cycle.
//  Latency/throughput:
//   - First instruction is visible the cycle after the first accepted success.
//   - Sustains 1 instr/cycle with success=1 and decodeReady=1.
//  Address bit31 (peripheral space) gets no special treatment; fetch flows through the MMU.
//  Guarantees: no instruction is duplicated or dropped across stalls or back-pressure.
//   fetchPc increments by exactly 4 between consecutive delivered words, except after a redirect.
// TESTING
//  1 Reset, success=1, decodeReady=1, mem returns data=addr^32'hA5A5_0000
//    -> fetchPc 0,4,8,... on consecutive cycles, data matches, fetchValid stays 1.
//  2 success=0 for 3 cycles at pc=0x8 -> address holds 0x8, fetchValid drops after consume,
//    fetchStallCycles=3, resumes with fetchPc=0x8.
//  3 decodeReady=0 for 4 cycles while success=1 -> FULL, fetchInstruction/fetchPc/address stable.
//    After release the sequence continues with no gaps or duplicates.
//  4 branchTaken=1, branchTarget=0x102 while success=1 at pc=0x10
//    -> next address=0x100, fetchValid=0, word for 0x10 never delivered, next fetchPc=0x100.
//  5 pc=0xFFFF_FFFC, success=1 -> next address 0x0000_0000 (wrap).
//    Force stall counter to all-ones -> stays 16'hFFFF.
//  6 reset=0 asserted during FULL and during a stall -> next cycle address=RESET_PC,
//    fetchValid=0, counter=0. branchTaken asserted together with reset is ignored.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, accepts MMU words on success, and hands them to decode through a
// one-entry valid/ready buffer. Also handles branch redirects and counts fetch stall cycles.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [31:0]            instructionMemoryAddress,
  input  logic                   instructionMemorySuccess,
  input  logic [31:0]            instructionMemoryDataIn,
  input  logic                   branchTaken,
  input  logic [31:0]            branchTarget,
  input  logic                   decodeReady,
  output logic                   fetchValid,
  output logic [31:0]            fetchInstruction,
  output logic [31:0]            fetchPc,
  output logic [STALL_CNT_W-1:0] fetchStallCycles
);

  typedef enum logic {
    FETCH = 1'b0,
    FULL  = 1'b1
  } fetchState_t;

  fetchState_t            state, stateNext;
  logic [31:0]            pc, pcNext;
  logic                   validNext;
  logic [31:0]            instrNext;
  logic [31:0]            bufPcNext;
  logic [STALL_CNT_W-1:0] stallNext;

  // Redirect targets are word aligned; the low target bits are dropped on purpose.
  logic unusedTargetBits;
  assign unusedTargetBits = ^branchTarget[1:0];

  assign instructionMemoryAddress = pc;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    validNext = fetchValid;
    instrNext = fetchInstruction;
    bufPcNext = fetchPc;
    stallNext = fetchStallCycles;

    if (branchTaken) begin
      // Redirect drops the buffered word and whatever the MMU returns this cycle.
      pcNext    = {branchTarget[31:2], 2'b00};
      validNext = 1'b0;
      stateNext = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (instructionMemorySuccess) begin
            if (!fetchValid || decodeReady) begin
              instrNext = instructionMemoryDataIn;
              bufPcNext = pc;
              validNext = 1'b1;
              pcNext    = pc + 32'd4;
            end else begin
              // Word is not captured; it is refetched from the same pc after the drain.
              stateNext = FULL;
            end
          end else begin
            if (fetchStallCycles != '1) stallNext = fetchStallCycles + 1'b1;
            if (fetchValid && decodeReady) validNext = 1'b0;
          end
        end
        FULL: begin
          if (decodeReady) begin
            validNext = 1'b0;
            stateNext = FETCH;
          end
        end
        default: stateNext = FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= FETCH;
      pc               <= RESET_PC;
      fetchValid       <= 1'b0;
      fetchInstruction <= 32'h0;
      fetchPc          <= 32'h0;
      fetchStallCycles <= '0;
    end else begin
      state            <= stateNext;
      pc               <= pcNext;
      fetchValid       <= validNext;
      fetchInstruction <= instrNext;
      fetchPc          <= bufPcNext;
      fetchStallCycles <= stallNext;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model
// and an in-order delivery scoreboard (data == pc ^ key, pc advances by 4 except after redirect).
module tb_instruction_fetch_unit;

  localparam logic [31:0] KEY      = 32'hA5A5_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instructionMemoryAddress;
  logic        instructionMemorySuccess = 1'b0;
  logic [31:0] instructionMemoryDataIn = 32'h0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = 32'h0;
  logic        decodeReady = 1'b0;
  logic        fetchValid;
  logic [31:0] fetchInstruction;
  logic [31:0] fetchPc;
  logic [15:0] fetchStallCycles;

  logic [31:0] smallAddress;
  logic        smallValid;
  logic [31:0] smallInstruction;
  logic [31:0] smallPc;
  logic [2:0]  smallStallCycles;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .instructionMemoryAddress(instructionMemoryAddress),
    .instructionMemorySuccess(instructionMemorySuccess),
    .instructionMemoryDataIn(instructionMemoryDataIn),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .decodeReady(decodeReady),
    .fetchValid(fetchValid), .fetchInstruction(fetchInstruction),
    .fetchPc(fetchPc), .fetchStallCycles(fetchStallCycles)
  );

  // Narrow-counter copy on the same stimulus exposes saturation in a few cycles.
  instruction_fetch_unit #(.RESET_PC(RESET_PC), .STALL_CNT_W(3)) dutSmall (
    .clk(clk), .reset(reset),
    .instructionMemoryAddress(smallAddress),
    .instructionMemorySuccess(instructionMemorySuccess),
    .instructionMemoryDataIn(instructionMemoryDataIn),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .decodeReady(decodeReady),
    .fetchValid(smallValid), .fetchInstruction(smallInstruction),
    .fetchPc(smallPc), .fetchStallCycles(smallStallCycles)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model state: what the fetch stage has promised decode, plus total stall cycles.
  logic [31:0] mPc;
  logic        mValid;
  logic [31:0] mInstr;
  logic [31:0] mFetchPc;
  logic        mWaitDrain;
  int          mStalls;
  bit          modelKnown = 1'b0;

  // Delivery scoreboard.
  logic [31:0] lastDelivered;
  bit          chainBroken = 1'b1;

  function automatic logic [31:0] satCount(input int count, input int maxVal);
    return (count > maxVal) ? maxVal : count;
  endfunction

  task automatic cycle(input logic r, input logic b, input logic [31:0] t,
                       input logic s, input logic d);
    logic [31:0] word;
    @(negedge clk);
    if (modelKnown) begin
      check("address",    instructionMemoryAddress, mPc);
      check("valid",      {31'b0, fetchValid}, {31'b0, mValid});
      check("instr",      fetchInstruction, mInstr);
      check("fetchPc",    fetchPc, mFetchPc);
      check("stall16",    {16'b0, fetchStallCycles}, satCount(mStalls, 16'hFFFF));
      check("stallSmall", {29'b0, smallStallCycles}, satCount(mStalls, 7));
      if (r && !b && fetchValid && d) begin
        check("seqData", fetchInstruction, fetchPc ^ KEY);
        if (!chainBroken) check("seqPc", fetchPc, lastDelivered + 32'd4);
        lastDelivered = fetchPc;
        chainBroken   = 1'b0;
      end
    end
    if (!r || b) chainBroken = 1'b1;

    word = s ? (instructionMemoryAddress ^ KEY) : $urandom;
    reset                    = r;
    branchTaken              = b;
    branchTarget             = t;
    instructionMemorySuccess = s;
    instructionMemoryDataIn  = word;
    decodeReady              = d;
    @(posedge clk);

    if (!r) begin
      mPc = RESET_PC; mValid = 1'b0; mInstr = 32'h0; mFetchPc = 32'h0;
      mStalls = 0; mWaitDrain = 1'b0; modelKnown = 1'b1;
    end else if (b) begin
      mPc = t & 32'hFFFF_FFFC; mValid = 1'b0; mWaitDrain = 1'b0;
    end else if (mWaitDrain) begin
      if (d) begin mValid = 1'b0; mWaitDrain = 1'b0; end
    end else if (s) begin
      if (!mValid || d) begin
        mInstr = word; mFetchPc = mPc; mValid = 1'b1; mPc = mPc + 32'd4;
      end else begin
        mWaitDrain = 1'b1;
      end
    end else begin
      mStalls++;
      if (mValid && d) mValid = 1'b0;
    end
  endtask

  initial begin
    // Reset and streaming.
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 32'h40, 1, 1);
    #1 check("rstAddr", instructionMemoryAddress, RESET_PC);
    check("rstValid", {31'b0, fetchValid}, 32'd0);
    cycle(1, 0, 0, 1, 1);
    #1 check("firstPc", fetchPc, 32'h0);
    check("firstData", fetchInstruction, 32'h0 ^ KEY);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, 1);
    #1 check("streamPc", fetchPc, 32'd20);
    check("streamAddr", instructionMemoryAddress, 32'd24);

    // Fetch stall with decode draining.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1);
    #1 check("stallCount", {16'b0, fetchStallCycles}, 32'd3);
    check("stallValid", {31'b0, fetchValid}, 32'd0);
    check("stallAddr", instructionMemoryAddress, 32'd24);
    cycle(1, 0, 0, 1, 1);
    #1 check("resumePc", fetchPc, 32'd24);

    // Back-pressure into FULL.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, 0);
    #1 check("fullAddr", instructionMemoryAddress, 32'd28);
    check("fullPc", fetchPc, 32'd24);
    check("fullData", fetchInstruction, 32'd24 ^ KEY);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 1);

    // Redirect with misaligned target.
    cycle(1, 1, 32'h102, 1, 1);
    #1 check("brAddr", instructionMemoryAddress, 32'h100);
    check("brValid", {31'b0, fetchValid}, 32'd0);
    cycle(1, 0, 0, 1, 1);
    #1 check("brPc", fetchPc, 32'h100);

    // PC wrap and counter saturation on the narrow instance.
    cycle(1, 1, 32'hFFFF_FFFC, 0, 0);
    cycle(1, 0, 0, 1, 1);
    #1 check("wrapAddr", instructionMemoryAddress, 32'h0);
    check("wrapPc", fetchPc, 32'hFFFF_FFFC);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 1);
    #1 check("satSmall", {29'b0, smallStallCycles}, 32'd7);

    // Reset during FULL and during a stall, with a simultaneous branch.
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 1, 32'h40, 1, 1);
    #1 check("rstFullAddr", instructionMemoryAddress, RESET_PC);
    check("rstFullValid", {31'b0, fetchValid}, 32'd0);
    check("rstFullStall", {16'b0, fetchStallCycles}, 32'd0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 32'h80, 0, 1);
    #1 check("rstStallAddr", instructionMemoryAddress, RESET_PC);
    check("rstStallCnt", {16'b0, fetchStallCycles}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0), $urandom,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end
    cycle(1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
